// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaler and period counter,
// per-channel duty compare, shadowed period/duty, center mode, period IRQ.
module pwm_multi_channel #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [3:0]        address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_irq
);

   logic              wr_en, rd_en;
   logic              en_q, center_q, irq_en_q;
   logic              en_d, center_d, irq_en_d;
   logic [NUM_CH-1:0] inv_q, inv_d;
   logic [CNT_W-1:0]  per_q, psc_q;
   logic [CNT_W-1:0]  duty_q [NUM_CH];
   logic [CNT_W-1:0]  per_a_q, psc_a_q;
   logic [CNT_W-1:0]  duty_a_q [NUM_CH];
   logic              mode_q;
   logic [CNT_W-1:0]  pcnt_q, pcnt_d, cnt_q, cnt_d;
   logic              down_q, down_d;
   logic              done_q, done_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              tick, bnd, load;
   logic              unused_wd;

   assign wr_en      = chipselect & write;
   assign rd_en      = chipselect & read;
   assign unused_wd  = ^writedata;
   assign readdata   = rdata_q;
   assign pwm_out    = pwm_q;
   assign period_irq = done_q & irq_en_q;

   always_comb begin
      en_d     = en_q;
      center_d = center_q;
      irq_en_d = irq_en_q;
      inv_d    = inv_q;
      if (wr_en && address == 4'd0) begin
         en_d     = writedata[0];
         center_d = writedata[1];
         irq_en_d = writedata[2];
         inv_d    = writedata[8 +: NUM_CH];
      end
   end

   // Boundary: edge wrap at top, or center turnaround back to zero.
   always_comb begin
      tick = en_q && (pcnt_q == psc_a_q);
      if (!mode_q)
         bnd = tick && (cnt_q == per_a_q);
      else if (down_q)
         bnd = tick && (cnt_q == CNT_W'(1));
      else
         bnd = tick && (cnt_q == per_a_q) && (per_a_q <= CNT_W'(1));
      load = !en_q || bnd;
   end

   always_comb begin
      pcnt_d = pcnt_q;
      cnt_d  = cnt_q;
      down_d = down_q;
      if (!en_d) begin
         pcnt_d = '0;
         cnt_d  = '0;
         down_d = 1'b0;
      end else if (en_q) begin
         pcnt_d = tick ? '0 : pcnt_q + CNT_W'(1);
         if (tick) begin
            if (bnd) begin
               cnt_d  = '0;
               down_d = 1'b0;
            end else if (mode_q && !down_q && cnt_q == per_a_q) begin
               cnt_d  = cnt_q - CNT_W'(1);
               down_d = 1'b1;
            end else if (down_q) begin
               cnt_d  = cnt_q - CNT_W'(1);
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      done_d = done_q;
      if (wr_en && address == 4'd1 && writedata[1])
         done_d = 1'b0;
      if (bnd)
         done_d = 1'b1;
      for (int n = 0; n < NUM_CH; n++)
         pwm_d[n] = en_q ? ((cnt_q < duty_a_q[n]) ^ inv_q[n]) : inv_q[n];
   end

   always_comb begin
      rdata_d = '0;
      case (address)
         4'd0: begin
            rdata_d[0]           = en_q;
            rdata_d[1]           = center_q;
            rdata_d[2]           = irq_en_q;
            rdata_d[8 +: NUM_CH] = inv_q;
         end
         4'd1: begin
            rdata_d[0]          = en_q;
            rdata_d[1]          = done_q;
            rdata_d[16 +: CNT_W] = cnt_q;
         end
         4'd2:    rdata_d[CNT_W-1:0] = per_q;
         4'd3:    rdata_d[CNT_W-1:0] = psc_q;
         default: begin
            for (int n = 0; n < NUM_CH; n++)
               if (address == 4'(4 + n))
                  rdata_d[CNT_W-1:0] = duty_q[n];
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q     <= 1'b0;
         center_q <= 1'b0;
         irq_en_q <= 1'b0;
         inv_q    <= '0;
         per_q    <= '0;
         psc_q    <= '0;
         per_a_q  <= '0;
         psc_a_q  <= '0;
         mode_q   <= 1'b0;
         pcnt_q   <= '0;
         cnt_q    <= '0;
         down_q   <= 1'b0;
         done_q   <= 1'b0;
         pwm_q    <= '0;
         rdata_q  <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            duty_q[n]   <= '0;
            duty_a_q[n] <= '0;
         end
      end else begin
         en_q     <= en_d;
         center_q <= center_d;
         irq_en_q <= irq_en_d;
         inv_q    <= inv_d;
         pcnt_q   <= pcnt_d;
         cnt_q    <= cnt_d;
         down_q   <= down_d;
         done_q   <= done_d;
         pwm_q    <= pwm_d;
         if (rd_en)
            rdata_q <= rdata_d;
         if (wr_en && address == 4'd2)
            per_q <= writedata[CNT_W-1:0];
         if (wr_en && address == 4'd3)
            psc_q <= writedata[CNT_W-1:0];
         for (int n = 0; n < NUM_CH; n++)
            if (wr_en && address == 4'(4 + n))
               duty_q[n] <= writedata[CNT_W-1:0];
         // Mode is sampled only while stopped so it switches on next enable.
         if (!en_q)
            mode_q <= center_d;
         if (load) begin
            per_a_q <= per_q;
            psc_a_q <= psc_q;
            for (int n = 0; n < NUM_CH; n++)
               duty_a_q[n] <= duty_q[n];
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_pwm_multi_channel;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              cs, wr, rd;
   logic [3:0]        addr;
   logic [31:0]       wdata, rdata;
   logic [NUM_CH-1:0] pwm;
   logic              irq;

   int vecs = 0;
   int errs = 0;
   int hi [NUM_CH];
   int c1, c2;
   logic found, prev;
   int seq [8];

   always #5 clk = ~clk;

   pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (cs),
      .write      (wr),
      .read       (rd),
      .address    (addr),
      .writedata  (wdata),
      .readdata   (rdata),
      .pwm_out    (pwm),
      .period_irq (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp,
                         input string tag);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      chk(tag, rdata, exp);
   endtask

   task automatic count_hi(input int n);
      for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) if (pwm[c]) hi[c]++;
      end
   endtask

   initial begin
      reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
      addr = '0; wdata = '0;
      seq = '{0, 1, 2, 3, 4, 3, 2, 1};
      #1;
      chk("rst_pwm", 32'(pwm), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Edge mode
      wr_reg(2, 9);
      wr_reg(3, 0);
      wr_reg(4, 3);
      wr_reg(5, 0);
      wr_reg(6, 10);
      wr_reg(7, 5);
      wr_reg(0, 32'h1);
      repeat (3) @(negedge clk);
      count_hi(10);
      chk("edge_ch0", hi[0], 3);
      chk("edge_ch1", hi[1], 0);
      chk("edge_ch2", hi[2], 10);
      chk("edge_ch3", hi[3], 5);
      count_hi(20);
      chk("edge_ch0_x2", hi[0], 6);
      rd_chk(2, 9, "rd_period");

      // Shadowing: retarget DUTY0 right after a period starts
      found = 1'b0;
      prev  = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (pwm[0] && !prev) found = 1'b1;
         prev = pwm[0];
      end
      chk("sh_sync", 32'(found), 32'h1);
      cs = 1'b1; wr = 1'b1; addr = 4; wdata = 7;
      c1 = 1; c2 = 0;
      for (int i = 1; i < 20; i++) begin
         @(negedge clk);
         if (i == 1) begin cs = 1'b0; wr = 1'b0; end
         if (pwm[0]) begin
            if (i < 10) c1++;
            else c2++;
         end
      end
      chk("sh_cur", c1, 3);
      chk("sh_next", c2, 7);
      rd_chk(4, 7, "sh_readback");

      // Center mode
      wr_reg(0, 32'h0);
      wr_reg(2, 4);
      wr_reg(3, 1);
      wr_reg(4, 2);
      wr_reg(0, 32'h3);
      cs = 1'b1; rd = 1'b1; addr = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("ctr_cnt%0d", i), 32'(rdata[31:16]), 32'(seq[i/2]));
      end
      cs = 1'b0; rd = 1'b0;
      count_hi(16);
      chk("ctr_ch0", hi[0], 6);

      // Polarity and disable
      wr_reg(0, 32'h103);
      wr_reg(0, 32'h100);
      @(negedge clk);
      chk("dis_pwm", 32'(pwm), 32'h1);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = 1;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      chk("dis_running", 32'(rdata[0]), 32'h0);
      chk("dis_cnt", 32'(rdata[31:16]), 32'h0);

      // Interrupt
      wr_reg(1, 32'h2);
      rd_chk(1, 32'h0, "irq_clr_status");
      wr_reg(2, 3);
      wr_reg(3, 0);
      wr_reg(0, 32'h5);
      repeat (3) @(negedge clk);
      chk("irq_early", 32'(irq), 32'h0);
      @(negedge clk);
      chk("irq_rise", 32'(irq), 32'h1);
      wr_reg(1, 32'h2);
      chk("irq_w1c", 32'(irq), 32'h0);
      wr_reg(1, 32'h2);
      chk("irq_set_wins", 32'(irq), 32'h1);

      // Reset mid-run
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_pwm", 32'(pwm), 32'h0);
      chk("mid_rst_irq", 32'(irq), 32'h0);
      chk("mid_rst_rdata", rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 8; a++)
         rd_chk(4'(a), 32'h0, $sformatf("rst_reg%0d", a));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel PWM generator with a memory-mapped CSR slave, for SoC peripherals that need several synchronised PWM outputs. It succeeds the single-channel PWM wrapper. The counter width and channel count are parameters. It adds center-aligned mode, per-channel output polarity, shadowed period/duty registers loaded at period boundaries, and a period-complete interrupt. All channels share one prescaler and one period counter; each channel has its own duty compare.

## Interface
- NUM_CH, 4: number of PWM channels, legal 1..8.
- CNT_W, 16: width of the period, prescaler and duty registers and of the counters, legal 8..16.

- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  slave select; qualifies read and write.
- write  in  1  write strobe.
- read  in  1  read strobe.
- address  in  4  word address.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- pwm_out  out  NUM_CH  PWM outputs, registered.
- period_irq  out  1  level interrupt, equal to period_done AND irq_en.

## Operation
- Register map (word address):
  - 0 CONTROL: [0] enable, [1] center mode, [2] irq_en, [8+n] invert for channel n.
  - 1 STATUS: [0] running (read-only), [1] period_done (sticky, write-1-to-clear), [16+CNT_W-1:16] live counter (read-only).
  - 2 PERIOD, 3 PRESCALER, 4+n DUTY[n] for n < NUM_CH. All are CNT_W bits, zero-extended on read, upper write bits ignored.
  - All other addresses read 0; writes to them are ignored.
- Shadowing:
  - PERIOD, PRESCALER and DUTY writes go to the programmed registers; readback always returns the programmed value.
  - Active copies load from the programmed registers at every period boundary, and continuously while enable=0.
- Prescaler:
  - psc counts 0..PRESCALER.
  - tick = (psc == active PRESCALER); psc wraps to 0 on tick.
- Edge mode (center=0):
  - On tick, cnt runs 0,1,..,PERIOD then wraps to 0.
  - Period = PERIOD+1 ticks; boundary = tick with cnt == PERIOD.
- Center mode (center=1):
  - On tick, cnt runs up 0..PERIOD then down to 1, repeating.
  - Period = 2*PERIOD ticks; boundary = tick with cnt == 1 while counting down.
  - PERIOD=1 gives the sequence 0,1,0,1.
- PERIOD=0 in either mode: cnt stays 0 and every tick is a boundary.
- Channel output: pwm_out[n] = (cnt < active DUTY[n]) XOR invert[n].
  - DUTY=0 gives constant inactive.
  - DUTY > PERIOD (edge mode) or DUTY > PERIOD (center mode) gives constant active.
- Disabled (enable=0):
  - psc, cnt and the direction bit are held at 0 (count up).
  - pwm_out = invert bits; running=0.
  - Mode changes take effect on the next enable.
- period_done sets at each boundary. A W1C clear in the same cycle as a set loses: the set wins.

## Timing
- Reset values: all registers, counters, readdata, pwm_out and period_irq are 0.
- A write commits on the clk edge where chipselect & write are high.
  - CONTROL bits act immediately.
  - Shadowed registers act per the loading rule in Operation.
- Read latency is 1 cycle: readdata is loaded at the edge where chipselect & read are high, and holds its value otherwise.
- Enable:
  - At the edge where enable becomes 1, psc=cnt=0 and the active copies hold the programmed values.
  - pwm_out reflects cnt=0 one clock later.
- pwm_out is registered from the current cnt and active DUTY, so it lags cnt by 1 clock.
- With PRESCALER=0 in edge mode, each channel is active for DUTY clocks out of PERIOD+1.
- Active-copy load and the period_done set happen on the boundary edge. The new values govern the first tick of the next period.
- Clearing enable mid-period stops counting at that edge; pwm_out goes to the invert level one clock later.
- Reset asserted mid-operation returns everything to reset values asynchronously.

## Test plan
- Reset: assert reset mid-run -> pwm_out=0 and period_irq=0 immediately; every register reads 0.
- Edge mode: NUM_CH=4, PERIOD=9, PRESCALER=0, DUTY={3,0,10,5}, enable -> over every 10 clocks, ch0 is high 3, ch1 is always 0, ch2 is always 1, ch3 is high 5.
- Shadowing: running with DUTY0=3, write DUTY0=7 mid-period -> the current period keeps 3 high clocks and the next has 7; readback of DUTY0 is 7 immediately.
- Center mode: PERIOD=4, PRESCALER=1, DUTY0=2 -> cnt follows 0,1,2,3,4,3,2,1 with each value lasting 2 clocks; ch0 is high 6 of every 16 clocks, centred on cnt=0.
- Polarity/disable: invert ch0, then clear enable -> ch0=1, other channels=0 one clock later; STATUS running=0 and counter=0.
- IRQ: irq_en=1, PERIOD=3, PRESCALER=0 -> period_irq rises after 4 clocks. Writing STATUS=0x2 clears it. A clear coinciding with a boundary leaves it set.
